// File: rtl/iir_biquad_cascade.sv
// Cascade of Direct-Form-I biquad sections sharing a single multiplier.
// One sample is accepted in IDLE. Each section then takes five MAC cycles
// and one write-back cycle. Results are rounded half-up and saturated to DATA_W.
module iir_biquad_cascade #(
   parameter int IN_W       = 10,
   parameter int DATA_W     = 12,
   parameter int COEF_W     = 16,
   parameter int FRAC       = 14,
   parameter int SECTIONS   = 2,
   parameter int ADDR_W     = 4,
   parameter int OFFSET_BIN = 1
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [IN_W-1:0]          in_data,
   input  logic                     coef_we,
   input  logic [ADDR_W-1:0]        coef_addr,
   input  logic [COEF_W-1:0]        coef_wdata,
   input  logic                     state_clr,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     sat_flag,
   output logic                     drop_flag
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = DATA_W + COEF_W + 4;
   localparam int SEC_W  = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;

   localparam logic signed [COEF_W-1:0] COEF_ONE   = COEF_W'(2 ** FRAC);
   localparam logic signed [ACC_W-1:0]  ROUND_HALF = ACC_W'(2 ** (FRAC - 1));
   localparam logic signed [ACC_W-1:0]  Y_MAX      = ACC_W'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [ACC_W-1:0]  Y_MIN      = ~Y_MAX;
   localparam logic [SEC_W-1:0]         LAST_SEC   = SEC_W'(SECTIONS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB} state_t;

   state_t                    state;
   logic [SEC_W-1:0]          sec;
   logic [2:0]                tap;
   logic signed [ACC_W-1:0]   acc;
   logic signed [DATA_W-1:0]  cur;

   // Coefficients are indexed as [section][tap], with taps ordered b0, b1, b2, a1, a2.
   logic signed [COEF_W-1:0]  coef [SECTIONS][5];
   logic signed [DATA_W-1:0]  x1 [SECTIONS];
   logic signed [DATA_W-1:0]  x2 [SECTIONS];
   logic signed [DATA_W-1:0]  y1 [SECTIONS];
   logic signed [DATA_W-1:0]  y2 [SECTIONS];

   logic [IN_W-1:0]           in_fix;
   logic signed [DATA_W-1:0]  in_sample;
   logic signed [COEF_W-1:0]  tap_coef;
   logic signed [DATA_W-1:0]  tap_data;
   logic                      tap_sub;
   logic signed [PROD_W-1:0]  product;
   logic signed [ACC_W-1:0]   acc_next;
   logic signed [ACC_W-1:0]   rounded;
   logic signed [DATA_W-1:0]  y_sat;
   logic                      wb_sat;

   // Offset-binary ADC codes become two's complement by flipping the MSB.
   assign in_fix    = in_data ^ {(OFFSET_BIN != 0), {(IN_W-1){1'b0}}};
   assign in_sample = DATA_W'($signed(in_fix));
   assign in_ready  = (state == S_IDLE);

   // Select this tap's coefficient and operand, then multiply and accumulate.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      tap_coef = '0;
      tap_data = '0;
      tap_sub  = 1'b0;
      case (tap)
         3'd0: begin tap_coef = coef[sec][0]; tap_data = cur;     end
         3'd1: begin tap_coef = coef[sec][1]; tap_data = x1[sec]; end
         3'd2: begin tap_coef = coef[sec][2]; tap_data = x2[sec]; end
         3'd3: begin tap_coef = coef[sec][3]; tap_data = y1[sec]; tap_sub = 1'b1; end
         3'd4: begin tap_coef = coef[sec][4]; tap_data = y2[sec]; tap_sub = 1'b1; end
         default: ;
      endcase
      product  = PROD_W'(tap_coef) * PROD_W'(tap_data);
      acc_next = tap_sub ? (acc - ACC_W'(product)) : (acc + ACC_W'(product));
   end

   // Round the accumulator half-up, drop the fraction bits, and clamp to the output range.
   always_comb begin
      rounded = (acc + ROUND_HALF) >>> FRAC;
      wb_sat  = 1'b0;
      y_sat   = rounded[DATA_W-1:0];
      if (rounded > Y_MAX) begin
         y_sat  = Y_MAX[DATA_W-1:0];
         wb_sat = 1'b1;
      end else if (rounded < Y_MIN) begin
         y_sat  = Y_MIN[DATA_W-1:0];
         wb_sat = 1'b1;
      end
   end

   // Sequencer: accept a sample, run MAC/WB for each section, then emit the result.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state     <= S_IDLE;
         sec       <= '0;
         tap       <= '0;
         acc       <= '0;
         cur       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
         drop_flag <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every register see pre-edge values of the others.
         out_valid <= 1'b0;
         if (in_valid && state != S_IDLE) drop_flag <= 1'b1;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  cur   <= in_sample;
                  sec   <= '0;
                  tap   <= '0;
                  acc   <= '0;
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc_next;
               if (tap == 3'd4) state <= S_WB;
               else             tap   <= tap + 3'd1;
            end
            S_WB: begin
               if (wb_sat) sat_flag <= 1'b1;
               cur <= y_sat;
               if (sec == LAST_SEC) begin
                  out_data  <= y_sat;
                  out_valid <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  sec   <= sec + 1'b1;
                  tap   <= '0;
                  acc   <= '0;
                  state <= S_MAC;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Coefficient table: passthrough after reset, writable only while idle.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         // NOTE: this array is reset explicitly because passthrough coefficients must exist before any write.
         for (int s = 0; s < SECTIONS; s++)
            for (int t = 0; t < 5; t++)
               coef[s][t] <= (t == 0) ? COEF_ONE : '0;
      end else if (state == S_IDLE && coef_we) begin
         for (int s = 0; s < SECTIONS; s++)
            for (int t = 0; t < 5; t++)
               if (coef_addr == ADDR_W'(s * 5 + t)) coef[s][t] <= coef_wdata;
      end
   end

   // Delay lines: cleared on reset or state_clr in IDLE, and shifted at each section's write-back.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n || (state == S_IDLE && state_clr)) begin
         for (int s = 0; s < SECTIONS; s++) begin
            x1[s] <= '0;
            x2[s] <= '0;
            y1[s] <= '0;
            y2[s] <= '0;
         end
      end else if (state == S_WB) begin
         x2[sec] <= x1[sec];
         x1[sec] <= cur;
         y2[sec] <= y1[sec];
         y1[sec] <= y_sat;
      end
   end

endmodule
